// File: rtl/bcd_display_controller.sv
//------------------------------------------------------------------------------
// bcd_display_controller
//   Captures a binary result, converts it to BCD (shift-add-3, one bit/clock)
//   and presents sign/overflow/leading-zero-blanked nibbles for 7-seg decoders.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_display_controller #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  signed_mode,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits_bcd,
    output logic                  sign_neg,
    output logic                  overflow
);

    localparam int INT_DIGITS = DATA_W / 3 + 1;
    localparam int ACC_DIGITS = (INT_DIGITS > DIGITS) ? INT_DIGITS : DIGITS;
    localparam int ACC_W      = 4 * ACC_DIGITS;
    localparam int CNT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_BLANK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [DATA_W-1:0]   data_cap;
    logic                smode_cap;
    logic                neg;
    logic [DATA_W-1:0]   mag;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_adj;
    logic [CNT_W-1:0]    cnt;
    logic [4*DIGITS-1:0] digits_nxt;
    logic                ovf_nxt;
    logic                lead;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                busy      = 1'b1;
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (cnt == '0) state_nxt = S_BLANK;
            end
            S_BLANK: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = start ? S_LOAD : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        acc_adj    = acc;
        ovf_nxt    = 1'b0;
        digits_nxt = '1;
        lead       = 1'b1;
        for (int i = 0; i < ACC_DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        for (int i = DIGITS; i < ACC_DIGITS; i++) begin
            if (acc[4*i +: 4] != 4'd0) ovf_nxt = 1'b1;
        end
        // Blank leading zeros from the top; digit 0 always shows.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (ovf_nxt) begin
                digits_nxt[4*i +: 4] = 4'hF;
            end else if (lead && (acc[4*i +: 4] == 4'd0) && (i != 0)) begin
                digits_nxt[4*i +: 4] = 4'hF;
            end else begin
                digits_nxt[4*i +: 4] = acc[4*i +: 4];
                lead                 = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_cap   <= '0;
            smode_cap  <= 1'b0;
            neg        <= 1'b0;
            mag        <= '0;
            acc        <= '0;
            cnt        <= '0;
            digits_bcd <= '1;
            sign_neg   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        data_cap  <= data_in;
                        smode_cap <= signed_mode;
                    end
                end
                S_LOAD: begin
                    // A negative operand is never zero, so neg alone drives sign_neg.
                    neg <= smode_cap & data_cap[DATA_W-1];
                    mag <= (smode_cap & data_cap[DATA_W-1]) ? (~data_cap + 1'b1) : data_cap;
                    acc <= '0;
                    cnt <= CNT_W'(DATA_W - 1);
                end
                S_SHIFT: begin
                    acc <= {acc_adj[ACC_W-2:0], mag[DATA_W-1]};
                    mag <= {mag[DATA_W-2:0], 1'b0};
                    cnt <= cnt - 1'b1;
                end
                S_BLANK: begin
                    digits_bcd <= digits_nxt;
                    overflow   <= ovf_nxt;
                    sign_neg   <= neg;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_controller.sv
//------------------------------------------------------------------------------
// tb_bcd_display_controller
//   Scoreboard bench: stimulus pushes expected results, a monitor checks on done.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_display_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] data_in;
    logic        signed_mode;
    logic        busy;
    logic        done;
    logic [15:0] digits_bcd;
    logic        sign_neg;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] digits;
        logic        sign;
        logic        ovf;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    bcd_display_controller #(.DATA_W(16), .DIGITS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .data_in     (data_in),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .digits_bcd  (digits_bcd),
        .sign_neg    (sign_neg),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got digits=%h sign=%b ovf=%b, required no done",
                         digits_bcd, sign_neg, overflow);
            end else begin
                mon_e = q.pop_front();
                checks += 2;
                if ({digits_bcd, sign_neg, overflow} !== {mon_e.digits, mon_e.sign, mon_e.ovf}) begin
                    errors++;
                    $display("FAIL %s: got digits=%h sign=%b ovf=%b, required digits=%h sign=%b ovf=%b",
                             mon_e.name, digits_bcd, sign_neg, overflow,
                             mon_e.digits, mon_e.sign, mon_e.ovf);
                end
                if (cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL %s_latency: done at cycle %0d, required %0d",
                             mon_e.name, cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic push_exp(input logic [15:0] ed, input logic es, input logic eo,
                            input int ec, input string nm);
        exp_t e;
        e.digits = ed;
        e.sign   = es;
        e.ovf    = eo;
        e.cyc    = ec;
        e.name   = nm;
        q.push_back(e);
    endtask

    // Called at a negedge; the accepting edge is the next posedge (edge 0).
    task automatic issue(input logic [15:0] d, input logic s, input logic [15:0] ed,
                         input logic es, input logic eo, input string nm);
        data_in     = d;
        signed_mode = s;
        start       = 1'b1;
        push_exp(ed, es, eo, cyc + 19, nm);
        @(negedge clk);
        start       = 1'b0;
        data_in     = ~d;
        signed_mode = ~s;
    endtask

    task automatic drain();
        for (int k = 0; k < 80 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    initial begin
        int c0;
        reset       = 1'b0;
        start       = 1'b0;
        data_in     = 16'h0;
        signed_mode = 1'b0;
        #12;
        check("reset_digits", 32'(digits_bcd), 32'hFFFF);
        check("reset_busy",   32'(busy),       32'd0);
        check("reset_done",   32'(done),       32'd0);
        check("reset_sign",   32'(sign_neg),   32'd0);
        check("reset_ovf",    32'(overflow),   32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        issue(16'd1234, 1'b0, 16'h1234, 1'b0, 1'b0, "u1234");     drain();
        issue(16'hFFF9, 1'b1, 16'hFFF7, 1'b1, 1'b0, "s_minus7");  drain();
        issue(16'h0000, 1'b1, 16'hFFF0, 1'b0, 1'b0, "s_zero");    drain();
        issue(16'd10000, 1'b0, 16'hFFFF, 1'b0, 1'b1, "u10000");   drain();
        issue(16'h8000, 1'b1, 16'hFFFF, 1'b1, 1'b1, "s_min");     drain();
        issue(16'd9999, 1'b0, 16'h9999, 1'b0, 1'b0, "u9999");     drain();

        // Start while busy must be ignored; outputs keep the last result meanwhile.
        issue(16'd1234, 1'b0, 16'h1234, 1'b0, 1'b0, "busy_first");
        repeat (5) @(negedge clk);
        data_in = 16'd5678;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        check("hold_during_conv", 32'(digits_bcd), 32'h9999);
        check("busy_mid_conv", 32'(busy), 32'd1);
        drain();
        repeat (25) @(negedge clk);
        check("busy_ignored_result", 32'(digits_bcd), 32'h1234);

        issue(16'd500,  1'b0, 16'hF500, 1'b0, 1'b0, "u500");      drain();
        issue(16'd1,    1'b0, 16'hFFF1, 1'b0, 1'b0, "u1");        drain();
        issue(16'hFFFF, 1'b1, 16'hFFF1, 1'b1, 1'b0, "s_minus1");  drain();
        issue(16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b1, "u65535");    drain();
        issue(16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1, "s_32767");   drain();

        // Start held high through DONE: second operand accepted back-to-back.
        c0          = cyc;
        data_in     = 16'd7;
        signed_mode = 1'b0;
        start       = 1'b1;
        push_exp(16'hFFF7, 1'b0, 1'b0, c0 + 19, "b2b_first");
        push_exp(16'h2024, 1'b0, 1'b0, c0 + 38, "b2b_second");
        @(negedge clk);
        data_in = 16'd2024;
        while (cyc < c0 + 21) @(negedge clk);
        start = 1'b0;
        drain();

        // Asynchronous reset mid-SHIFT aborts the conversion.
        c0          = cyc;
        data_in     = 16'd1234;
        signed_mode = 1'b0;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_busy",   32'(busy),       32'd0);
        check("abort_digits", 32'(digits_bcd), 32'hFFFF);
        check("abort_done",   32'(done),       32'd0);
        check("abort_ovf",    32'(overflow),   32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (25) @(negedge clk);
        check("abort_no_result", 32'(digits_bcd), 32'hFFFF);

        issue(16'd42, 1'b0, 16'hFF42, 1'b0, 1'b0, "u42");         drain();
        repeat (25) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
